// File: rtl/axis_bram_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : axis_bram_fifo_reader
// Description : Read-side controller of a BRAM-backed AXI-Stream FIFO. It
//               issues one-cycle RAM reads and absorbs the read latency in a
//               2-entry output buffer. Optional AXIS_BRAM_FIFO_READER_LEVEL_EN
//               adds a registered rd_level_o occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_bram_fifo_reader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [ADDRESS_WIDTH:0]   wr_ptr_i,
  output logic [ADDRESS_WIDTH:0]   rd_ptr_o,
  output logic                     reb,
  output logic [ADDRESS_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0]    doutb,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata
`ifdef AXIS_BRAM_FIFO_READER_LEVEL_EN
  ,
  output logic [ADDRESS_WIDTH+1:0] rd_level_o
`endif
);

  logic [ADDRESS_WIDTH:0]  r_rd_ptr;
  logic                    r_in_flight;
  logic [1:0]              r_stored;
  logic [DATA_WIDTH-1:0]   r_head;
  logic [DATA_WIDTH-1:0]   r_skid;

  logic                    w_empty;
  logic                    w_pop;
  logic [2:0]              w_after;
  logic                    w_to_head;

  assign w_empty = (wr_ptr_i == r_rd_ptr);
  assign w_pop   = m_axis_tvalid & m_axis_tready;

  // Buffer occupancy after this edge if no new read is issued; stored plus
  // in-flight never exceeds 2, so a read is only issued when a slot is free.
  assign w_after = {1'b0, r_stored} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign reb     = !w_empty && (w_after < 3'd2);

  assign w_to_head = (r_stored == 2'd0) || (w_pop && (r_stored == 2'd1));

  assign rd_ptr_o      = r_rd_ptr;
  assign addrb         = r_rd_ptr[ADDRESS_WIDTH-1:0];
  assign m_axis_tvalid = (r_stored != 2'd0);
  assign m_axis_tdata  = r_head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr    <= '0;
      r_in_flight <= 1'b0;
      r_stored    <= 2'd0;
      r_head      <= '0;
      r_skid      <= '0;
    end else begin
      r_in_flight <= reb;
      r_stored    <= w_after[1:0];
      if (reb) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (r_in_flight) begin
        if (w_to_head) begin
          r_head <= doutb;
        end else begin
          r_skid <= doutb;
        end
      end else if (w_pop && (r_stored == 2'd2)) begin
        r_head <= r_skid;
      end
    end
  end

`ifdef AXIS_BRAM_FIFO_READER_LEVEL_EN
  localparam int c_lvl_w = ADDRESS_WIDTH + 2;

  logic [ADDRESS_WIDTH:0]  w_ram_occ;
  logic [c_lvl_w-1:0]      r_level;

  assign w_ram_occ  = wr_ptr_i - r_rd_ptr;
  assign rd_level_o = r_level;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_level <= '0;
    end else begin
      r_level <= c_lvl_w'(w_ram_occ) + c_lvl_w'(r_stored) + c_lvl_w'(r_in_flight);
    end
  end
`endif

endmodule
`default_nettype wire
